// File: rtl/draw_scheduler.sv
// draw_scheduler: upstream sequencer for the rectangle draw engine.
// Game logic pushes draw requests into a small FIFO. Each request is issued
// in turn: load the engine (IDLE->LOAD), run it until eng_done (RUN), then
// give the engine one cleared cycle (FLUSH) before the next request.
//
// Optional feature: define DRAW_SCHED_TIMEOUT_EN to enable the RUN watchdog.
// Without it, timeout_err is tied low and RUN waits for eng_done indefinitely.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req_valid/ready   request handshake (ready = FIFO not full)
//   req_x/y/w/h/c     request origin, size codes and colour
//   obj_x/y/w/h/c     registered object presented to the engine
//   eng_reset_n       low = engine latches obj_x/obj_y and clears
//   eng_enable        engine step enable
//   eng_done          engine finished (registered in the engine)
//   plot              VGA write enable for the engine's current pixel
//   busy              active object or queued requests present
//   timeout_err       1-cycle pulse on watchdog abort
module draw_scheduler #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned TIMEOUT = 1200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_x,
   input  logic [6:0] req_y,
   input  logic [4:0] req_w,
   input  logic [4:0] req_h,
   input  logic [2:0] req_c,
   output logic [7:0] obj_x,
   output logic [6:0] obj_y,
   output logic [4:0] obj_w,
   output logic [4:0] obj_h,
   output logic [2:0] obj_c,
   output logic       eng_reset_n,
   output logic       eng_enable,
   input  logic       eng_done,
   output logic       plot,
   output logic       busy,
   output logic       timeout_err
);

   localparam int unsigned ENTRY_W = 28;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [ENTRY_W-1:0]  r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wptr;
   logic [ADDR_W-1:0]   r_rptr;
   logic [ADDR_W:0]     r_count;
   logic                w_full;
   logic                w_empty;
   logic                w_push;
   logic                w_pop;
   logic                w_abort;
   logic [ENTRY_W-1:0]  w_head;

   // Full is decoded from the registered count only, so a pop in the same
   // cycle never opens a slot for a push.
   assign w_full    = (r_count == (ADDR_W+1)'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign req_ready = !w_full;
   assign w_push    = req_valid && !w_full;
   assign w_pop     = (r_state == S_IDLE) && !w_empty;
   assign w_head    = r_mem[r_rptr];
   assign busy      = (r_state != S_IDLE) || !w_empty;

   // Storage needs no reset: only entries covered by r_count are ever read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {req_x, req_y, req_w, req_h, req_c};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Object registers change only on the IDLE->LOAD edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         obj_x <= '0;
         obj_y <= '0;
         obj_w <= '0;
         obj_h <= '0;
         obj_c <= '0;
      end else if (w_pop) begin
         {obj_x, obj_y, obj_w, obj_h, obj_c} <= w_head;
      end
   end

`ifdef DRAW_SCHED_TIMEOUT_EN
   localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

   logic [TCNT_W-1:0] r_tcnt;
   logic              r_timeout_err;

   // Abort on the TIMEOUT-th RUN cycle; the error pulse lands in FLUSH,
   // where plot is already low.
   assign w_abort = (r_state == S_RUN) && !eng_done &&
                    (r_tcnt == TCNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tcnt        <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_abort;
         if (r_state == S_LOAD) begin
            r_tcnt <= '0;
         end else if (r_state == S_RUN) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_abort     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      eng_reset_n = 1'b0;
      eng_enable  = 1'b0;
      plot        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) w_next = S_LOAD;
         end
         S_LOAD: begin
            w_next = S_RUN;
         end
         S_RUN: begin
            eng_reset_n = 1'b1;
            eng_enable  = 1'b1;
            plot        = !eng_done;
            if (eng_done || w_abort) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Testbench for draw_scheduler: behavioural engine stub, scoreboard of
// issued objects checked at each RUN entry, and per-scenario tasks.
module tb_draw_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_x = '0;
   logic [6:0] req_y = '0;
   logic [4:0] req_w = '0;
   logic [4:0] req_h = '0;
   logic [2:0] req_c = '0;
   logic [7:0] obj_x;
   logic [6:0] obj_y;
   logic [4:0] obj_w;
   logic [4:0] obj_h;
   logic [2:0] obj_c;
   logic       eng_reset_n;
   logic       eng_enable;
   logic       eng_done;
   logic       plot;
   logic       busy;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   draw_scheduler #(
      .DEPTH   (8),
      .ADDR_W  (3),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_w       (req_w),
      .req_h       (req_h),
      .req_c       (req_c),
      .obj_x       (obj_x),
      .obj_y       (obj_y),
      .obj_w       (obj_w),
      .obj_h       (obj_h),
      .obj_c       (obj_c),
      .eng_reset_n (eng_reset_n),
      .eng_enable  (eng_enable),
      .eng_done    (eng_done),
      .plot        (plot),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Engine stub: done rises after done_after enabled cycles since last load.
   int   done_after = 5;
   logic stub_never = 1'b0;
   logic force_done = 1'b0;
   logic stub_done  = 1'b0;
   int   stub_cnt   = 0;

   always @(posedge clk) begin
      if (!eng_reset_n) begin
         stub_cnt  <= 0;
         stub_done <= 1'b0;
      end else if (eng_enable) begin
         stub_cnt  <= stub_cnt + 1;
         stub_done <= !stub_never && (stub_cnt + 1 >= done_after);
      end
   end
   assign eng_done = stub_done | force_done;

   // Scoreboard and run monitor.
   logic [27:0] exp_q[$];
   int          run_start_q[$];
   int          run_end_q[$];
   int          plot_q[$];
   logic        load_rstn_q[$];
   int          done_objs = 0;
   logic        prev_en = 1'b0;
   logic        prev_rstn = 1'b0;
   int          cur_plots = 0;
   logic [27:0] cur_obj = '0;
   logic [27:0] exp_obj;

   always @(negedge clk) begin
      if (!reset) begin
         if (prev_en) begin
            plot_q.push_back(cur_plots);
            run_end_q.push_back(cyc);
            done_objs++;
         end
         prev_en = 1'b0;
      end else begin
         if (eng_enable && !prev_en) begin
            run_start_q.push_back(cyc);
            load_rstn_q.push_back(prev_rstn);
            cur_obj   = {obj_x, obj_y, obj_w, obj_h, obj_c};
            cur_plots = 0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_object: got %h, required no object", cur_obj);
            end else begin
               exp_obj = exp_q.pop_front();
               if (cur_obj !== exp_obj) begin
                  errors++;
                  $display("FAIL sb_object: got %h, required %h", cur_obj, exp_obj);
               end
            end
         end
         if (eng_enable) begin
            checks++;
            if ({obj_x, obj_y, obj_w, obj_h, obj_c} !== cur_obj) begin
               errors++;
               $display("FAIL obj_stable_in_run: got %h, required %h",
                        {obj_x, obj_y, obj_w, obj_h, obj_c}, cur_obj);
            end
            if (plot === 1'b1) cur_plots++;
         end
         if (!eng_enable && prev_en) begin
            plot_q.push_back(cur_plots);
            run_end_q.push_back(cyc);
            done_objs++;
         end
         prev_en = eng_enable;
      end
      prev_rstn = eng_reset_n;
   end

   task automatic push_req(input logic [7:0] x, input logic [6:0] y,
                           input logic [4:0] w, input logic [4:0] h,
                           input logic [2:0] c, output int t);
      int waitc = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_x = x; req_y = y; req_w = w; req_h = h; req_c = c;
      while (!req_ready && waitc < 300) begin
         @(negedge clk);
         waitc++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL push_wait: req_ready stayed %b, required 1", req_ready);
      end else begin
         exp_q.push_back({x, y, w, h, c});
      end
      t = cyc;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int k = 0;
      while (done_objs < n && k < 600) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (done_objs < n) begin
         checks++;
         errors++;
         $display("FAIL wait_done: completed %0d objects, required %0d", done_objs, n);
      end
   endtask

   task automatic wait_run();
      int k = 0;
      while (eng_enable !== 1'b1 && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (eng_enable !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_run: eng_enable %b, required 1", eng_enable);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({obj_x, obj_y, obj_w, obj_h, obj_c} !== 28'd0) begin
         errors++;
         $display("FAIL reset_obj: got %h, required 0", {obj_x, obj_y, obj_w, obj_h, obj_c});
      end
      checks++;
      if ({eng_reset_n, eng_enable, plot, busy, timeout_err, req_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 000001",
                  {eng_reset_n, eng_enable, plot, busy, timeout_err, req_ready});
      end
      reset = 1'b1;
   endtask

   task automatic test_single();
      int base = done_objs;
      int t;
      stub_never = 1'b0;
      done_after = 5;
      push_req(8'd10, 7'd20, 5'd3, 5'd2, 3'd4, t);
      wait_done(base + 1);
      checks++;
      if (run_start_q[base] - t !== 3) begin
         errors++;
         $display("FAIL single_latency: got %0d, required 3", run_start_q[base] - t);
      end
      checks++;
      if (plot_q[base] !== 5) begin
         errors++;
         $display("FAIL single_plot_cycles: got %0d, required 5", plot_q[base]);
      end
      checks++;
      if (busy !== 1'b1 || eng_reset_n !== 1'b0) begin
         errors++;
         $display("FAIL single_flush: busy %b eng_reset_n %b, required 1 0", busy, eng_reset_n);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_idle: got %b, required 0", busy);
      end
      checks++;
      if ({obj_x, obj_y, obj_w, obj_h, obj_c} !== {8'd10, 7'd20, 5'd3, 5'd2, 3'd4}) begin
         errors++;
         $display("FAIL single_obj_hold: got %h, required %h",
                  {obj_x, obj_y, obj_w, obj_h, obj_c}, {8'd10, 7'd20, 5'd3, 5'd2, 3'd4});
      end
   endtask

   task automatic test_fifo_full();
      int base = done_objs;
      int t;
      stub_never = 1'b1;
      done_after = 1;
      push_req(8'd159, 7'd119, 5'd31, 5'd31, 3'd7, t);
      wait_run();
      for (int i = 1; i <= 8; i++) begin
         push_req(8'(i * 16), 7'(i * 10), 5'(i), 5'(31 - i), 3'(i), t);
      end
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_ready: got %b, required 0", req_ready);
      end
      fork
         push_req(8'd99, 7'd88, 5'd9, 5'd8, 3'd5, t);
         begin
            repeat (6) @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 1'b0 || req_valid !== 1'b1) begin
               errors++;
               $display("FAIL full_hold: ready %b valid %b, required 0 1", req_ready, req_valid);
            end
            stub_never = 1'b0;
         end
      join
      wait_done(base + 10);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL full_drain: %0d objects left, required 0", exp_q.size());
      end
      for (int i = 1; i < 10; i++) begin
         checks++;
         if (plot_q[base + i] !== 1) begin
            errors++;
            $display("FAIL full_plot_%0d: got %0d, required 1", i, plot_q[base + i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int base = done_objs;
      int t;
      stub_never = 1'b0;
      done_after = 1;
      push_req(8'd1, 7'd2, 5'd3, 5'd4, 3'd5, t);
      push_req(8'd6, 7'd7, 5'd8, 5'd9, 3'd2, t);
      wait_done(base + 2);
      checks++;
      if (run_start_q[base + 1] - run_end_q[base] !== 3) begin
         errors++;
         $display("FAIL b2b_gap: got %0d, required 3", run_start_q[base + 1] - run_end_q[base]);
      end
      checks++;
      if (load_rstn_q[base] !== 1'b0 || load_rstn_q[base + 1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b_load_rstn: got %b %b, required 0 0", load_rstn_q[base], load_rstn_q[base + 1]);
      end
      checks++;
      if (plot_q[base] !== 1 || plot_q[base + 1] !== 1) begin
         errors++;
         $display("FAIL b2b_plots: got %0d %0d, required 1 1", plot_q[base], plot_q[base + 1]);
      end
   endtask

   task automatic test_reset_mid_run();
      int   t;
      logic seen = 1'b0;
      stub_never = 1'b1;
      push_req(8'd50, 7'd60, 5'd7, 5'd7, 3'd1, t);
      wait_run();
      for (int i = 0; i < 3; i++) begin
         push_req(8'(70 + i), 7'(i), 5'(i), 5'(i), 3'(i), t);
      end
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({obj_x, obj_y, obj_w, obj_h, obj_c} !== 28'd0) begin
         errors++;
         $display("FAIL midrst_obj: got %h, required 0", {obj_x, obj_y, obj_w, obj_h, obj_c});
      end
      checks++;
      if ({eng_reset_n, eng_enable, plot, busy, timeout_err, req_ready} !== 6'b000001) begin
         errors++;
         $display("FAIL midrst_ctrl: got %b, required 000001",
                  {eng_reset_n, eng_enable, plot, busy, timeout_err, req_ready});
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      stub_never = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (plot !== 1'b0 || eng_enable !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL midrst_quiet: activity %b, required 0", seen);
      end
   endtask

   task automatic test_timeout();
      int   base = done_objs;
      int   t;
      int   te = 0;
      int   k = 0;
      logic bad_plot = 1'b0;
`ifdef DRAW_SCHED_TIMEOUT_EN
      stub_never = 1'b1;
      push_req(8'd33, 7'd44, 5'd5, 5'd6, 3'd3, t);
      while (done_objs <= base && k < 200) begin
         @(negedge clk);
         #1;
         k++;
         if (timeout_err === 1'b1) begin
            te++;
            if (plot !== 1'b0) bad_plot = 1'b1;
         end
      end
      repeat (4) begin
         @(negedge clk);
         #1;
         if (timeout_err === 1'b1) te++;
      end
      checks++;
      if (te !== 1) begin
         errors++;
         $display("FAIL timeout_pulses: got %0d, required 1", te);
      end
      checks++;
      if (bad_plot !== 1'b0) begin
         errors++;
         $display("FAIL timeout_plot: got %b, required 0", bad_plot);
      end
      checks++;
      if (done_objs <= base || plot_q[base] !== 16 || run_end_q[base] - run_start_q[base] !== 16) begin
         errors++;
         $display("FAIL timeout_run_len: done %0d plots %0d, required 16 16", done_objs - base,
                  (done_objs > base) ? plot_q[base] : -1);
      end
      stub_never = 1'b0;
      done_after = 3;
      push_req(8'd34, 7'd45, 5'd6, 5'd7, 3'd2, t);
      wait_done(base + 2);
      checks++;
      if (plot_q[base + 1] !== 3) begin
         errors++;
         $display("FAIL timeout_next: got %0d, required 3", plot_q[base + 1]);
      end
`else
      stub_never = 1'b1;
      push_req(8'd33, 7'd44, 5'd5, 5'd6, 3'd3, t);
      wait_run();
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (timeout_err !== 1'b0) te++;
      end
      checks++;
      if (eng_enable !== 1'b1 || te !== 0) begin
         errors++;
         $display("FAIL no_watchdog: enable %b err_cycles %0d, required 1 0", eng_enable, te);
      end
      stub_never = 1'b0;
      done_after = 1;
      wait_done(base + 1);
      checks++;
      if (busy !== 1'b1 || eng_enable !== 1'b0) begin
         errors++;
         $display("FAIL no_watchdog_release: busy %b enable %b, required 1 0", busy, eng_enable);
      end
`endif
   endtask

   task automatic test_done_on_entry();
      int base = done_objs;
      int t;
      force_done = 1'b1;
      push_req(8'd120, 7'd100, 5'd4, 5'd4, 3'd6, t);
      wait_done(base + 1);
      checks++;
      if (plot_q[base] !== 0) begin
         errors++;
         $display("FAIL doneentry_plots: got %0d, required 0", plot_q[base]);
      end
      checks++;
      if (run_end_q[base] - run_start_q[base] !== 1) begin
         errors++;
         $display("FAIL doneentry_run_len: got %0d, required 1", run_end_q[base] - run_start_q[base]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || eng_reset_n !== 1'b0) begin
         errors++;
         $display("FAIL doneentry_idle: busy %b eng_reset_n %b, required 0 0", busy, eng_reset_n);
      end
      force_done = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_fifo_full();
      test_back_to_back();
      test_reset_mid_run();
      test_timeout();
      test_done_on_entry();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
